// File: rtl/gmux_ctrl_pkg.sv
// Shared types and constants for the AP3 global clock mux sequencing controller.
package gmux_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_GATE,
    ST_SWITCH,
    ST_UNGATE,
    ST_RESUME,
    ST_LP
  } state_e;

  typedef logic [3:0] qmask_t;

  // Bit positions inside every {TR,TL,BR,BL} quadrant vector.
  localparam int unsigned Q_BL = 0;
  localparam int unsigned Q_BR = 1;
  localparam int unsigned Q_TL = 2;
  localparam int unsigned Q_TR = 3;

  localparam logic SEL_CLK  = 1'b0;
  localparam logic SEL_HSCK = 1'b1;

endpackage

// File: rtl/gmux_ctrl_timer.sv
// Settle timer: loadable down-counter that flags expiry once it reaches zero.
module gmux_ctrl_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == '0);

endmodule

// File: rtl/gmux_ctrl.sv
// Sequencing controller for one GMUX site: gates, switches and re-enables the
// quadrant clocks with settle-timed steps so no quadrant ever sees a runt pulse.
module gmux_ctrl
  import gmux_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       SW_REQ,
  input  logic       SW_SEL,
  input  logic [3:0] QEN_REQ,
  input  logic       LP_REQ,
  output logic       SSEL,
  output logic [3:0] DEN,
  output logic [3:0] DYNEN,
  output logic [3:0] SEN,
  output logic [3:0] VLP,
  output logic       CUR_SEL,
  output logic       BUSY,
  output logic       DONE,
  output logic       LP_ACK
);

  state_e state, state_nxt;
  qmask_t mask, mask_nxt;
  logic   psel, psel_nxt;
  logic   lp_flag, lp_flag_nxt;

  // Requests are captured one edge ahead of the FSM; a switch pulse seen while
  // BUSY is high is discarded at capture so it cannot fire after the sequence.
  logic   sw_req_q, sw_sel_q, lp_req_q;
  qmask_t qen_q;

  logic   ssel_nxt, cur_sel_nxt, done_nxt;
  qmask_t den_nxt, dynen_nxt, sen_nxt, vlp_nxt;

  logic   timer_load, timer_expire;

  gmux_ctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (timer_load),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .expire   (timer_expire)
  );

  // Every state change reloads the timer so each wait state lasts SETTLE_CYCLES.
  assign timer_load = (state_nxt != state);

  // NOTE: every always_comb output gets a default first; a path that forgets
  // to assign would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    mask_nxt    = mask;
    psel_nxt    = psel;
    lp_flag_nxt = lp_flag;
    ssel_nxt    = SSEL;
    cur_sel_nxt = CUR_SEL;
    den_nxt     = DEN;
    dynen_nxt   = DYNEN;
    sen_nxt     = SEN;
    vlp_nxt     = VLP;
    done_nxt    = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (lp_req_q) begin
          lp_flag_nxt = 1'b1;
          state_nxt   = ST_DRAIN;
          dynen_nxt   = '0;
        end else if (sw_req_q) begin
          lp_flag_nxt = 1'b0;
          psel_nxt    = sw_sel_q;
          mask_nxt    = qen_q;
          if (sw_sel_q == CUR_SEL && qen_q == mask) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
            dynen_nxt = '0;
          end
        end else if (qen_q != mask) begin
          lp_flag_nxt = 1'b0;
          mask_nxt    = qen_q;
          psel_nxt    = CUR_SEL;
          state_nxt   = ST_DRAIN;
          dynen_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (timer_expire) begin
          state_nxt = ST_GATE;
          den_nxt   = '0;
          sen_nxt   = '0;
        end
      end
      ST_GATE: begin
        if (timer_expire) begin
          if (lp_flag) begin
            state_nxt = ST_LP;
            vlp_nxt   = mask;
          end else begin
            state_nxt = ST_SWITCH;
            ssel_nxt  = psel;
          end
        end
      end
      ST_SWITCH: begin
        if (timer_expire) begin
          state_nxt   = ST_UNGATE;
          cur_sel_nxt = psel;
          vlp_nxt     = '0;
          den_nxt     = mask;
          sen_nxt     = mask;
        end
      end
      ST_UNGATE: begin
        if (timer_expire) begin
          state_nxt = ST_RESUME;
          dynen_nxt = mask;
          done_nxt  = 1'b1;
        end
      end
      ST_RESUME: begin
        state_nxt = ST_IDLE;
      end
      ST_LP: begin
        if (!lp_req_q) begin
          state_nxt   = ST_UNGATE;
          lp_flag_nxt = 1'b0;
          vlp_nxt     = '0;
          den_nxt     = mask;
          sen_nxt     = mask;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      mask     <= '0;
      psel     <= SEL_CLK;
      lp_flag  <= 1'b0;
      sw_req_q <= 1'b0;
      sw_sel_q <= SEL_CLK;
      lp_req_q <= 1'b0;
      qen_q    <= '0;
      SSEL     <= SEL_CLK;
      CUR_SEL  <= SEL_CLK;
      DEN      <= '0;
      DYNEN    <= '0;
      SEN      <= '0;
      VLP      <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      LP_ACK   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mask     <= mask_nxt;
      psel     <= psel_nxt;
      lp_flag  <= lp_flag_nxt;
      sw_req_q <= SW_REQ & ~BUSY;
      sw_sel_q <= SW_SEL;
      lp_req_q <= LP_REQ;
      qen_q    <= QEN_REQ;
      SSEL     <= ssel_nxt;
      CUR_SEL  <= cur_sel_nxt;
      DEN      <= den_nxt;
      DYNEN    <= dynen_nxt;
      SEN      <= sen_nxt;
      VLP      <= vlp_nxt;
      BUSY     <= (state_nxt != ST_IDLE);
      DONE     <= done_nxt;
      LP_ACK   <= (state_nxt == ST_LP);
    end
  end

endmodule

// File: tb/tb_gmux_ctrl.sv
// Bench for gmux_ctrl: scenario tasks compared against a timeline model of the
// sequencing rules, plus a per-cycle monitor of the gating order guarantees.
module tb_gmux_ctrl;
  import gmux_ctrl_pkg::*;

  localparam int S        = 4;
  localparam int DONE_BIT = 17;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       SW_REQ, SW_SEL, LP_REQ;
  logic [3:0] QEN_REQ;
  logic       SSEL, CUR_SEL, BUSY, DONE, LP_ACK;
  logic [3:0] DEN, DYNEN, SEN, VLP;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_model   = 4'h0;
  logic       sel_model = SEL_CLK;

  gmux_ctrl #(.SETTLE_CYCLES(S)) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .SW_REQ  (SW_REQ),
    .SW_SEL  (SW_SEL),
    .QEN_REQ (QEN_REQ),
    .LP_REQ  (LP_REQ),
    .SSEL    (SSEL),
    .DEN     (DEN),
    .DYNEN   (DYNEN),
    .SEN     (SEN),
    .VLP     (VLP),
    .CUR_SEL (CUR_SEL),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .LP_ACK  (LP_ACK)
  );

  always #5 CLK = ~CLK;

  // Ordering guarantees, sampled mid-cycle while out of reset.
  logic       prev_ssel = 1'b0;
  logic [3:0] prev_den  = 4'h0;
  logic [3:0] prev_sen  = 4'h0;
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      for (int q = Q_BL; q <= Q_TR; q++) begin
        total++;
        if ((DYNEN[q] && !DEN[q]) || (VLP[q] && DEN[q])) begin
          bad++;
          $display("FAIL order_q%0d got den=%b dynen=%b vlp=%b need dynen<=den and vlp&den=0",
                   q, DEN[q], DYNEN[q], VLP[q]);
        end
      end
      total++;
      if (SSEL !== prev_ssel && (prev_den | prev_sen | DEN | SEN) != 4'h0) begin
        bad++;
        $display("FAIL ssel_gated got ssel %b->%b with den=%h sen=%h need den=sen=0",
                 prev_ssel, SSEL, DEN, SEN);
      end
    end
    prev_ssel = SSEL;
    prev_den  = DEN;
    prev_sen  = SEN;
  end

  task automatic wait_edge();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [20:0] observed();
    return {SSEL, CUR_SEL, BUSY, DONE, LP_ACK, DEN, SEN, DYNEN, VLP};
  endfunction

  // Expected outputs t edges after the request edge. u is the edge at which the
  // enables return: 3S+1 for a switch, one edge after LP exit for low power.
  function automatic logic [20:0] model_at(int t, bit lp, int u, logic [3:0] m_old,
                                           logic [3:0] m_new, logic s_old, logic s_new);
    logic ssel, cur, busy, done, ack;
    logic [3:0] den, dyn, vlp;
    ssel = s_old; cur = s_old; busy = 1'b0; done = 1'b0; ack = 1'b0;
    den = m_old; dyn = m_old; vlp = 4'h0;
    if (t <= 0) begin
    end else if (t <= S) begin
      busy = 1'b1; dyn = 4'h0;
    end else if (t <= 2 * S) begin
      busy = 1'b1; dyn = 4'h0; den = 4'h0;
    end else if (t < u) begin
      busy = 1'b1; dyn = 4'h0; den = 4'h0;
      if (lp) begin
        ack = 1'b1; vlp = m_old;
      end else begin
        ssel = s_new;
      end
    end else if (t < u + S) begin
      busy = 1'b1; dyn = 4'h0; den = m_new; ssel = s_new; cur = s_new;
    end else if (t == u + S) begin
      busy = 1'b1; done = 1'b1; den = m_new; dyn = m_new; ssel = s_new; cur = s_new;
    end else begin
      den = m_new; dyn = m_new; ssel = s_new; cur = s_new;
    end
    return {ssel, cur, busy, done, ack, den, den, dyn, vlp};
  endfunction

  // Issues one request (switch, mask change or low power) and compares every
  // edge of the resulting sequence plus a quiet tail against the model.
  task automatic run_seq(input string name, input bit lp, input bit use_sw,
                         input logic [3:0] m_new, input logic s_new,
                         input int drop_t, input int inject_t, input int tail);
    logic [3:0] m_old;
    logic       s_old;
    logic [20:0] obs, exp_v;
    int u, last, k;
    m_old = m_model;
    s_old = sel_model;
    if (lp) begin
      m_new = m_old;
      s_new = s_old;
    end
    u = 3 * S + 1;
    if (lp) begin
      k = drop_t + 1;
      u = ((k > 2 * S + 1) ? k : 2 * S + 1) + 1;
    end
    last = u + S + 1 + tail;
    QEN_REQ = m_new;
    SW_REQ  = use_sw;
    SW_SEL  = s_new;
    LP_REQ  = lp;
    wait_edge();
    for (int t = 0; t <= last; t++) begin
      obs   = observed();
      exp_v = model_at(t, lp, u, m_old, m_new, s_old, s_new);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL %s t=%0d got=%h need=%h", name, t, obs, exp_v);
      end
      if (t == 0) SW_REQ = 1'b0;
      if (t == inject_t) begin
        SW_REQ = 1'b1;
        SW_SEL = 1'($urandom);
      end else if (t == inject_t + 1) begin
        SW_REQ = 1'b0;
      end
      if (lp && t == drop_t) LP_REQ = 1'b0;
      if (t < last) wait_edge();
    end
    SW_REQ    = 1'b0;
    LP_REQ    = 1'b0;
    m_model   = m_new;
    sel_model = s_new;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; SW_REQ = 1'b0; SW_SEL = SEL_CLK; LP_REQ = 1'b0; QEN_REQ = 4'hF;
    wait_edge();
    wait_edge();
    total++;
    if (observed() !== 21'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h need=0", observed());
    end
    RST_N = 1'b1;
    run_seq("boot", 1'b0, 1'b0, 4'hF, SEL_CLK, -1, -1, 2);
  endtask

  task automatic test_switch();
    run_seq("switch_hsck", 1'b0, 1'b1, m_model, SEL_HSCK, -1, -1, 2);
  endtask

  task automatic test_noop();
    logic [20:0] obs, exp_v;
    SW_REQ = 1'b1; SW_SEL = sel_model; QEN_REQ = m_model;
    wait_edge();
    SW_REQ = 1'b0;
    for (int t = 0; t <= 4; t++) begin
      obs   = observed();
      exp_v = model_at(0, 1'b0, 0, m_model, m_model, sel_model, sel_model);
      exp_v[DONE_BIT] = (t == 1);
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL noop t=%0d got=%h need=%h", t, obs, exp_v);
      end
      if (t < 4) wait_edge();
    end
  endtask

  task automatic test_back_to_back();
    run_seq("busy_drop_early", 1'b0, 1'b1, m_model, ~sel_model, -1, 3, 4);
    run_seq("busy_drop_resume", 1'b0, 1'b1, m_model, ~sel_model, -1, 4 * S + 1, 4);
  endtask

  task automatic test_mask_update();
    run_seq("mask_f_to_3", 1'b0, 1'b0, 4'h3, sel_model, -1, -1, 2);
    run_seq("mask_3_to_0", 1'b0, 1'b0, 4'h0, sel_model, -1, -1, 2);
    run_seq("mask_0_to_5", 1'b0, 1'b0, 4'h5, sel_model, -1, -1, 2);
  endtask

  task automatic test_low_power();
    run_seq("lp_hold", 1'b1, 1'b0, 4'h0, 1'b0, 2 * S + 3, -1, 2);
    run_seq("lp_early_drop", 1'b1, 1'b0, 4'h0, 1'b0, 2, -1, 2);
  endtask

  task automatic test_reset_mid();
    logic s_new;
    s_new  = ~sel_model;
    SW_REQ = 1'b1; SW_SEL = s_new; QEN_REQ = m_model;
    wait_edge();
    SW_REQ = 1'b0;
    repeat (2 * S + 2) wait_edge();
    total++;
    if (SSEL !== s_new) begin
      bad++;
      $display("FAIL mid_switch_ssel got=%b need=%b", SSEL, s_new);
    end
    #3 RST_N = 1'b0;
    #1;
    total++;
    if (observed() !== 21'h0) begin
      bad++;
      $display("FAIL async_reset got=%h need=0", observed());
    end
    wait_edge();
    total++;
    if (observed() !== 21'h0) begin
      bad++;
      $display("FAIL reset_hold got=%h need=0", observed());
    end
    QEN_REQ   = 4'hF;
    RST_N     = 1'b1;
    m_model   = 4'h0;
    sel_model = SEL_CLK;
    run_seq("reboot", 1'b0, 1'b0, 4'hF, SEL_CLK, -1, -1, 2);
  endtask

  task automatic test_random();
    logic [3:0] m_new;
    logic       s_new;
    int         op, inj;
    for (int i = 0; i < 14; i++) begin
      op    = int'($urandom_range(0, 3));
      m_new = 4'($urandom);
      s_new = 1'($urandom);
      inj   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 4 * S + 1)) : -1;
      case (op)
        0: begin
          if (s_new == sel_model && m_new == m_model) test_noop();
          else run_seq("rand_switch", 1'b0, 1'b1, m_new, s_new, -1, inj, 2);
        end
        1: begin
          if (m_new == m_model) m_new = ~m_model;
          run_seq("rand_mask", 1'b0, 1'b0, m_new, sel_model, -1, inj, 2);
        end
        2: run_seq("rand_lp", 1'b1, 1'b0, 4'h0, 1'b0,
                   int'($urandom_range(0, 2 * S + 6)), -1, 2);
        default: test_noop();
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_noop();
    test_back_to_back();
    test_mask_update();
    test_low_power();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gmux_ctrl.md
# gmux_ctrl

Sequencing controller for one AP3 global clock mux site. It drives the GMUX select (SSEL) and the per-quadrant enables DEN, DYNEN, SEN and VLP for BL, BR, TL and TR. Source switches, quadrant-mask updates and very-low-power entry/exit are all performed as a gated, settle-timed sequence, so no quadrant sees a runt clock. It sits between the fabric clock-management logic and the GMUX primitive, one instance per GMUX.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles spent in each wait state; legal range ≥1.
- CNT_W, $clog2(SETTLE_CYCLES+1), width of the settle counter (derived).

Ports:
- CLK  in  1  controller clock (free-running, independent of the muxed clocks).
- RST_N  in  1  asynchronous active-low reset.
- SW_REQ  in  1  single-cycle switch request; ignored while BUSY=1.
- SW_SEL  in  1  target source, sampled with SW_REQ; 0=GCLKIN, 1=GHSCK.
- QEN_REQ  in  4  requested quadrant enable mask {TR,TL,BR,BL}.
- LP_REQ  in  1  level request for low-power mode.
- SSEL  out  1  GMUX source select.
- DEN, DYNEN, SEN, VLP  out  4 each  per-quadrant enables, bit order {TR,TL,BR,BL}.
- CUR_SEL  out  1  committed source.
- BUSY  out  1  a sequence is in progress.
- DONE  out  1  one-cycle completion pulse.
- LP_ACK  out  1  high while in the LP state.

## Operation
- State register values: IDLE, DRAIN, GATE, SWITCH, UNGATE, RESUME, LP.
- Internal registers: active mask M, pending select P.
- Reset: all outputs 0, M=0, P=0, state IDLE. Reset is asynchronous at any point, including mid-sequence.
- IDLE request priority (evaluated each cycle):
  - LP_REQ=1 → DRAIN, with the LP flag set.
  - Otherwise SW_REQ=1 → P←SW_SEL, M←QEN_REQ, then DRAIN.
  - Otherwise QEN_REQ≠M → M←QEN_REQ, P←CUR_SEL, then DRAIN. After reset with a nonzero QEN_REQ, this path is the boot enable.
- No-op switch: SW_REQ with SW_SEL=CUR_SEL and QEN_REQ=M → DONE pulses next cycle, BUSY stays 0, state stays IDLE.
- Per-state actions (each wait state holds SETTLE_CYCLES cycles; counter loaded on entry):
  - DRAIN: DYNEN←0, then wait.
  - GATE: DEN←0 and SEN←0, then wait. Next state is LP if the LP flag is set, otherwise SWITCH.
  - SWITCH: SSEL←P, then wait. CUR_SEL←P on exit.
  - UNGATE: VLP←0, DEN←M, SEN←M, then wait.
  - RESUME: DYNEN←M, DONE=1 for this one cycle, then IDLE.
- LP state: VLP←M, LP_ACK=1. Exit when LP_REQ=0 → UNGATE (SSEL unchanged).
- Requests arriving while BUSY:
  - SW_REQ pulses are dropped.
  - QEN_REQ changes are re-evaluated only in IDLE.
  - If LP_REQ falls during the LP sequence's DRAIN/GATE, the controller still enters LP, then exits on the next cycle.
- M=0 is legal: the sequence runs normally and all enables end at 0.

## Timing
- All outputs are registered and change on the CLK edge that enters the state.
- Full switch latency, with S=SETTLE_CYCLES and the request sampled at edge 0:
  - DRAIN outputs appear at edge 1.
  - SSEL changes at edge 2S+1.
  - DEN/SEN reassert at edge 3S+1.
  - DYNEN and DONE at edge 4S+1.
  - IDLE at edge 4S+2.
  - BUSY is high over edges 1..4S+1. With S=4, DONE arrives at edge 17.
- Ordering guarantees:
  - SSEL never changes while any DEN or SEN bit is 1.
  - DYNEN is never 1 while the matching DEN is 0.
  - VLP bits are never 1 at the same time as DEN.
- LP entry: LP_ACK at edge 2S+1. LP exit: LP_REQ low sampled at edge k → DONE at edge k+S+1.

## Structure
- Package gmux_ctrl_pkg holds:
  - the state enum;
  - quadrant index constants Q_BL=0, Q_BR=1, Q_TL=2, Q_TR=3;
  - SEL_CLK=0 and SEL_HSCK=1.
- Sub-module gmux_ctrl_timer: a loadable down-counter of width CNT_W. It takes a load strobe and asserts an expire flag when the count reaches 0.
- The FSM and output registers live in gmux_ctrl.

## Test plan
- Boot: release reset with QEN_REQ=4'b1111, S=4 → DEN=SEN=DYNEN=4'hF, DONE at edge 17, SSEL=0 throughout.
- Switch: from the booted state, SW_REQ with SW_SEL=1 → DYNEN=0 at +1, DEN=0 at +5, SSEL=1 at +9, DEN=F at +13, DONE and DYNEN=F at +17, CUR_SEL=1. Checker asserts the ordering invariants on every cycle.
- No-op and busy drop:
  - SW_SEL=CUR_SEL with an unchanged mask → DONE at +1 and BUSY never asserted.
  - A second SW_REQ during BUSY → ignored, with exactly one DONE.
- Low power: LP_REQ=1 with M=4'b0101 → LP_ACK=1 and VLP=0101 at +9. Drop LP_REQ → VLP=0 and DEN=0101 on the next edge, then DONE 4 cycles later.
- Mask update: change QEN_REQ 4'hF→4'h3 in IDLE → full sequence with SSEL unchanged, final DEN=SEN=DYNEN=4'h3.
- Reset mid-sequence: assert RST_N low during SWITCH → all outputs 0 immediately (asynchronous), state IDLE. After release, the boot sequence reruns.
